// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson sequencing controller: command op-codes,
// direction constants and the controller FSM state type.
package johnson_pkg;

  // Command op-codes carried on cmd_op.
  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Step direction carried on cmd_dir.
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STEP    = 2'd2,
    RECOVER = 2'd3
  } state_e;

endpackage : johnson_pkg

// File: rtl/johnson_ctrl_if.sv
// Command interface of the Johnson controller (valid/ready handshake).
//   cmd_valid  : command offered (master -> slave)
//   cmd_ready  : command accepted when high together with cmd_valid at a rising edge
//   cmd_op     : STOP / RUN / STEP / LOAD
//   cmd_dir    : 0 forward, 1 reverse (RUN and STEP)
//   cmd_laps   : RUN lap target, 0 = free-run
//   cmd_data   : raw LOAD value
interface johnson_ctrl_if #(
  parameter int N     = 4,
  parameter int LAP_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [LAP_W-1:0] cmd_laps;
  logic [N-1:0]     cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_laps, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_laps, cmd_data,
    output cmd_ready
  );
endinterface : johnson_ctrl_if

// File: rtl/johnson_decode.sv
// Combinational decoder for an N-stage Johnson register.
//   q         : register value
//   legal     : q is a valid Johnson pattern (at most one adjacent-bit change)
//   phase_idx : position 0..2N-1 in the forward sequence (0 when illegal)
//   phase     : one-hot of phase_idx (all zero when illegal)
module johnson_decode #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(2*N)
) (
  input  logic [N-1:0]     q,
  output logic             legal,
  output logic [IDX_W-1:0] phase_idx,
  output logic [2*N-1:0]   phase
);

  int unsigned trans;
  int unsigned ones;
  int unsigned idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional logic, otherwise a path that skips an assignment infers a latch.
  always_comb begin
    trans = 0;
    ones  = 0;
    for (int i = 0; i < N; i++) begin
      ones = ones + 32'(q[i]);
    end
    for (int i = 0; i < N-1; i++) begin
      trans = trans + 32'(q[i] ^ q[i+1]);
    end
    legal = (trans <= 1);

    // Ones fill from the MSB during the first half of the sequence and drain
    // from the MSB during the second half; q[0] tells which half we are in.
    idx = q[0] ? (2*N - ones) : ones;

    phase_idx = '0;
    phase     = '0;
    if (legal) begin
      phase_idx = IDX_W'(idx);
      phase     = (2*N)'(1) << phase_idx;
    end
  end

endmodule : johnson_decode

// File: rtl/johnson_ctrl.sv
// Johnson counter sequencing controller.
//   clk, rst  : clock; asynchronous active-low reset
//   cmd       : command interface (slave side)
//   q         : Johnson register
//   phase_idx : decoded position, phase : one-hot phase
//   busy      : high while running, done : one-cycle completion pulse
//   err       : sticky illegal-pattern flag, lap_cnt : laps completed in this RUN
module johnson_ctrl
  import johnson_pkg::*;
#(
  parameter int N     = 4,
  parameter int LAP_W = 8,
  parameter int IDX_W = $clog2(2*N)
) (
  input  logic             clk,
  input  logic             rst,
  johnson_ctrl_if.slave    cmd,
  output logic [N-1:0]     q,
  output logic [IDX_W-1:0] phase_idx,
  output logic [2*N-1:0]   phase,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LAP_W-1:0] lap_cnt
);

  state_e           state_q, state_d;
  logic [N-1:0]     q_q, q_d;
  logic             dir_q, dir_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             legal;
  logic             ready;
  logic             cmd_fire;
  logic [N-1:0]     q_adv;
  logic [LAP_W-1:0] lap_inc;

  johnson_decode #(.N(N), .IDX_W(IDX_W)) u_decode (
    .q         (q_q),
    .legal     (legal),
    .phase_idx (phase_idx),
    .phase     (phase)
  );

  assign ready         = ((state_q == IDLE) || (state_q == RUN)) && legal;
  assign cmd.cmd_ready = ready;
  assign cmd_fire      = cmd.cmd_valid && ready;

  // One advance of the register in the latched direction.
  assign q_adv   = (dir_q == DIR_REV) ? {q_q[N-2:0], ~q_q[N-1]}
                                      : {~q_q[0], q_q[N-1:1]};
  assign lap_inc = lap_cnt_q + LAP_W'(1);

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    dir_d     = dir_q;
    laps_d    = laps_q;
    lap_cnt_d = lap_cnt_q;
    done_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (!legal) begin
          state_d = RECOVER;
        end else if (cmd_fire) begin
          case (cmd.cmd_op)
            OP_RUN: begin
              dir_d     = cmd.cmd_dir;
              laps_d    = cmd.cmd_laps;
              lap_cnt_d = '0;
              state_d   = RUN;
            end
            OP_STEP: begin
              dir_d   = cmd.cmd_dir;
              state_d = STEP;
            end
            OP_LOAD: q_d = cmd.cmd_data;
            default: ;
          endcase
        end
      end

      RUN: begin
        if (!legal) begin
          state_d = RECOVER;
        end else if (cmd_fire && (cmd.cmd_op == OP_STOP)) begin
          // STOP beats a lap target that would be reached on this edge.
          state_d = IDLE;
        end else if (cmd_fire && (cmd.cmd_op == OP_RUN)) begin
          // Restart: the advance on this edge is suppressed.
          dir_d     = cmd.cmd_dir;
          laps_d    = cmd.cmd_laps;
          lap_cnt_d = '0;
        end else begin
          // STEP/LOAD while running are accepted and dropped.
          q_d = q_adv;
          if (q_adv == '0) begin
            lap_cnt_d = lap_inc;
            if ((laps_q != '0) && (lap_inc == laps_q)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end

      STEP: begin
        if (!legal) begin
          state_d = RECOVER;
        end else begin
          q_d     = q_adv;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      RECOVER: begin
        q_d     = '0;
        err_d   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      q_q       <= '0;
      dir_q     <= DIR_FWD;
      laps_q    <= '0;
      lap_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      dir_q     <= dir_d;
      laps_q    <= laps_d;
      lap_cnt_q <= lap_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign q       = q_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign err     = err_q;
  assign lap_cnt = lap_cnt_q;

endmodule : johnson_ctrl

// File: tb/tb_johnson_ctrl.sv
// Self-checking bench for johnson_ctrl: directed scenarios followed by random
// commands, all compared against a position-based reference model.
module tb_johnson_ctrl;
  import johnson_pkg::*;

  localparam int N     = 4;
  localparam int LAP_W = 8;
  localparam int IDX_W = $clog2(2*N);
  localparam int M     = 2*N;

  localparam int MD_IDLE = 0;
  localparam int MD_RUN  = 1;
  localparam int MD_STEP = 2;
  localparam int MD_REC  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  johnson_ctrl_if #(.N(N), .LAP_W(LAP_W)) cmd_if ();

  logic [N-1:0]     q;
  logic [IDX_W-1:0] phase_idx;
  logic [M-1:0]     phase;
  logic             busy, done, err;
  logic [LAP_W-1:0] lap_cnt;

  johnson_ctrl #(.N(N), .LAP_W(LAP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd_if.slave),
    .q         (q),
    .phase_idx (phase_idx),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .lap_cnt   (lap_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_seen = 0;

  // Reference model state.
  int           m_mode;
  logic [N-1:0] m_val;
  bit           m_err, m_done, m_dir;
  int           m_lap, m_laps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Johnson value at sequence position k.
  function automatic logic [N-1:0] jval(input int k);
    logic [N-1:0] v = '0;
    if (k <= N) begin
      for (int i = 0; i < k; i++) v[N-1-i] = 1'b1;
    end else begin
      for (int i = 0; i < M-k; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Position of v in the sequence; legal=0 when it does not occur.
  task automatic jpos(input logic [N-1:0] v, output bit legal, output int idx);
    legal = 0;
    idx   = 0;
    for (int k = 0; k < M; k++) begin
      if (jval(k) == v) begin
        legal = 1;
        idx   = k;
      end
    end
  endtask

  task automatic model_reset();
    m_mode = MD_IDLE; m_val = '0; m_err = 0; m_done = 0;
    m_dir = 0; m_lap = 0; m_laps = 0;
  endtask

  task automatic check_outputs(input string tag);
    bit lg;
    int ix;
    jpos(m_val, lg, ix);
    check({tag, "_q"},     32'(q),                m_val);
    check({tag, "_idx"},   32'(phase_idx),        lg ? ix : 0);
    check({tag, "_phase"}, 32'(phase),            lg ? (32'd1 << ix) : 32'd0);
    check({tag, "_busy"},  32'(busy),             32'(m_mode == MD_RUN));
    check({tag, "_done"},  32'(done),             32'(m_done));
    check({tag, "_err"},   32'(err),              32'(m_err));
    check({tag, "_lap"},   32'(lap_cnt),          32'(m_lap));
    check({tag, "_rdy"},   32'(cmd_if.cmd_ready),
          32'(((m_mode == MD_IDLE) || (m_mode == MD_RUN)) && lg));
  endtask

  // One clock: drive, compare, predict, clock, commit. Entered just after a negedge.
  task automatic cycle(input bit v, input logic [1:0] op, input bit d,
                       input int laps, input logic [N-1:0] data, input string tag);
    bit           lg, fire;
    int           ix, nix;
    int           n_mode, n_lap, n_laps;
    logic [N-1:0] n_val;
    bit           n_err, n_done, n_dir;

    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_dir   = d;
    cmd_if.cmd_laps  = LAP_W'(laps);
    cmd_if.cmd_data  = data;
    check_outputs(tag);
    if (done === 1'b1) done_seen++;

    jpos(m_val, lg, ix);
    fire   = v && ((m_mode == MD_IDLE) || (m_mode == MD_RUN)) && lg;
    n_mode = m_mode; n_val = m_val; n_err = m_err; n_done = 0;
    n_dir  = m_dir;  n_lap = m_lap; n_laps = m_laps;
    nix    = m_dir ? (ix + M - 1) % M : (ix + 1) % M;

    case (m_mode)
      MD_IDLE: begin
        if (!lg) n_mode = MD_REC;
        else if (fire) begin
          if (op == OP_RUN) begin
            n_dir = d; n_laps = laps; n_lap = 0; n_mode = MD_RUN;
          end else if (op == OP_STEP) begin
            n_dir = d; n_mode = MD_STEP;
          end else if (op == OP_LOAD) begin
            n_val = data;
          end
        end
      end
      MD_RUN: begin
        if (!lg) n_mode = MD_REC;
        else if (fire && op == OP_STOP) n_mode = MD_IDLE;
        else if (fire && op == OP_RUN) begin
          n_dir = d; n_laps = laps; n_lap = 0;
        end else begin
          n_val = jval(nix);
          if (nix == 0) begin
            n_lap = (m_lap + 1) % (1 << LAP_W);
            if (m_laps != 0 && n_lap == m_laps) begin
              n_done = 1; n_mode = MD_IDLE;
            end
          end
        end
      end
      MD_STEP: begin
        if (!lg) n_mode = MD_REC;
        else begin
          n_val = jval(nix); n_done = 1; n_mode = MD_IDLE;
        end
      end
      default: begin
        n_val = '0; n_err = 1; n_mode = MD_IDLE;
      end
    endcase

    @(posedge clk);
    m_mode = n_mode; m_val = n_val; m_err = n_err; m_done = n_done;
    m_dir = n_dir; m_lap = n_lap; m_laps = n_laps;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(0, OP_STOP, 0, 0, '0, tag);
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_STOP;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_laps  = '0;
    cmd_if.cmd_data  = '0;
    model_reset();
    @(negedge clk);
    check_outputs("rst");
    rst = 1'b1;

    // RUN forward, two laps.
    done_seen = 0;
    cycle(1, OP_RUN, DIR_FWD, 2, '0, "run2");
    idle(20, "run2");
    check("run2_final_q", 32'(q), 32'h0);
    check("run2_final_lap", 32'(lap_cnt), 32'd2);
    check("run2_done_cnt", done_seen, 1);

    // RUN reverse, free-running, stopped after 20 advances.
    done_seen = 0;
    cycle(1, OP_RUN, DIR_REV, 0, '0, "free");
    idle(20, "free");
    cycle(1, OP_STOP, 0, 0, '0, "free_stop");
    idle(2, "free_after");
    check("free_q", 32'(q), 32'b1111);
    check("free_lap", 32'(lap_cnt), 32'd2);
    check("free_done_cnt", done_seen, 0);

    // Six forward steps from zero.
    cycle(1, OP_LOAD, 0, 0, 4'b0000, "ld0");
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, OP_STEP, DIR_FWD, 0, '0, "step");
      cycle(1, OP_STEP, DIR_FWD, 0, '0, "step_busy");
      idle(1, "step_idle");
    end
    idle(1, "step_end");
    check("step6_q", 32'(q), 32'b0011);
    check("step6_idx", 32'(phase_idx), 32'd6);
    check("step6_phase", 32'(phase), 32'h40);
    check("step6_done_cnt", done_seen, 6);

    // Illegal LOAD and recovery.
    cycle(1, OP_LOAD, 0, 0, 4'b0110, "bad_ld");
    idle(2, "recover");
    check("recover_q", 32'(q), 32'h0);
    check("recover_err", 32'(err), 32'd1);
    cycle(1, OP_LOAD, 0, 0, 4'b1100, "ld_c");
    idle(1, "ld_c");
    check("ld_c_idx", 32'(phase_idx), 32'd2);
    check("ld_c_err", 32'(err), 32'd1);

    // STOP on the edge that would complete the only lap.
    cycle(1, OP_LOAD, 0, 0, 4'b0000, "ld0b");
    done_seen = 0;
    cycle(1, OP_RUN, DIR_FWD, 1, '0, "race");
    idle(7, "race");
    cycle(1, OP_STOP, 0, 0, '0, "race_stop");
    idle(3, "race_after");
    check("race_q", 32'(q), 32'b0001);
    check("race_lap", 32'(lap_cnt), 32'd0);
    check("race_busy", 32'(busy), 32'd0);
    check("race_done_cnt", done_seen, 0);

    // Asynchronous reset in the middle of a RUN.
    cycle(1, OP_LOAD, 0, 0, 4'b0000, "ld0c");
    cycle(1, OP_RUN, DIR_FWD, 0, '0, "arst");
    idle(3, "arst");
    check("arst_pre_q", 32'(q), 32'b1110);
    rst = 1'b0;
    #1;
    model_reset();
    check("arst_q", 32'(q), 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_lap", 32'(lap_cnt), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    idle(5, "arst_after");
    check("arst_done_cnt", done_seen, 0);

    // Random commands.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3),
            N'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_johnson_ctrl

// File: doc/johnson_ctrl.md
Name: johnson_ctrl

Overview:
- Sequencing controller that owns an N-stage Johnson counter register and drives it from a small command interface.
- Commands: run (free-running or for a fixed number of laps), single-step, stop, and preset load, in either direction.
- Decodes the counter state into a phase index and a one-hot phase vector for downstream timing logic.
- Continuously checks the register for illegal (non-Johnson) patterns and forces recovery to the all-zero state.

Parameters:
- N, 4, number of Johnson stages; the sequence has 2N states.
- LAP_W, 8, width of the lap target and lap counter.
- IDX_W, $clog2(2*N), width of the phase index (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
- cmd_op  in  2  00 STOP, 01 RUN, 10 STEP, 11 LOAD.
- cmd_dir  in  1  0 forward, 1 reverse; used by RUN and STEP.
- cmd_laps  in  LAP_W  RUN lap target; 0 means free-run.
- cmd_data  in  N  LOAD value, written raw.
- q  out  N  Johnson register.
- phase_idx  out  IDX_W  decoded position 0..2N-1.
- phase  out  2N  one-hot phase, bit phase_idx set.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse on lap target reached or STEP complete.
- err  out  1  sticky flag: an illegal pattern was detected.
- lap_cnt  out  LAP_W  laps completed in the current RUN.

Behaviour:
- Reset (rst low, asynchronous): q=0, state=IDLE, busy=0, done=0, err=0, lap_cnt=0.
- Step functions:
  - Forward: q <= {~q[0], q[N-1:1]}.
  - Reverse: q <= {q[N-2:0], ~q[N-1]}.
- Legality: q is legal iff adjacent-bit transitions over q[0..N-1] (non-cyclic) number <= 1.
- Phase decode:
  - If q[0]==0, idx = popcount(q); else idx = 2N - popcount(q). For N=4, forward order is 0000,1000,1100,1110,1111,0111,0011,0001.
  - When q is illegal: phase_idx=0 and phase=0.
- cmd_ready = (state==IDLE or state==RUN) and q legal.
- FSM states: IDLE, RUN, STEP, RECOVER.
- IDLE:
  - RUN: latch dir and laps, lap_cnt<=0, go to RUN; the first advance happens on the next edge.
  - STEP: latch dir, go to STEP.
  - LOAD: q<=cmd_data, stay in IDLE.
  - STOP: no-op.
- RUN:
  - Advance q every cycle.
  - Each advance that lands on idx 0 increments lap_cnt; free-run wraps modulo 2^LAP_W.
  - If laps!=0 and the increment makes lap_cnt==laps: done pulses in the following cycle (registered), and the state goes to IDLE in the same edge.
- RUN command handling:
  - STOP accepted: no advance on that edge, go to IDLE.
  - RUN accepted: restart with new dir/laps, lap_cnt<=0, and the advance on that edge is suppressed.
  - STEP and LOAD are accepted and ignored.
- RUN boundary cases:
  - STOP in the same cycle as the final lap: STOP wins (no advance), the target is not reached, and done does not pulse.
  - Direction is fixed for the whole RUN; idx 0 is reached every 2N advances from idx 0 in either direction.
- STEP: advance once, done pulses in the next cycle, return to IDLE. cmd_ready=0 while in STEP.
- Illegal q in IDLE, RUN or STEP: the next state is RECOVER and q is held for that edge.
- RECOVER: q<=0, err<=1, go to IDLE; cmd_ready=0.
- Illegal LOAD timeline, accepted at edge k: q illegal after k; state=RECOVER after k+1; q=0, err=1, IDLE after k+2.
- err is cleared only by reset.
- Reset asserted mid-RUN: immediate return to the reset values, no done pulse.

Decomposition:
- Shared package johnson_pkg:
  - op-code localparams (OP_STOP, OP_RUN, OP_STEP, OP_LOAD);
  - FSM state enum (IDLE, RUN, STEP, RECOVER);
  - DIR_FWD and DIR_REV constants.
- One sub-module, johnson_decode: combinational; input q; outputs legal, phase_idx, phase.

Test Plan:
- Reset, then RUN dir=0 laps=2 with N=4 -> q walks 1000..0001,0000 twice; lap_cnt reaches 2; done pulses once at cycle 17 after accept; busy drops; q=0000.
- RUN dir=1 laps=0 for 20 cycles, then STOP -> q order 0001,0011,0111,1111,1110,...; lap_cnt=2; q frozen at the value present when STOP was accepted; no done.
- Six STEP commands from q=0000, dir=0 -> q=0011, phase_idx=6, phase=8'b0100_0000; six done pulses; cmd_ready low one cycle per STEP.
- LOAD 0110 -> cmd_ready drops, RECOVER entered, q=0000, err=1 two cycles after accept; a later LOAD 1100 gives phase_idx=2 and err stays 1.
- RUN laps=1 with STOP asserted on the cycle q returns 0001->0000 -> STOP wins, no done, lap_cnt=0, state IDLE.
- Reset pulsed low mid-RUN at q=1110 -> q=0, busy=0, lap_cnt=0 immediately (asynchronous); no done pulse after release.
